// File: rtl/waveform_pkg.sv
// Shared types and defaults for the shift/count sequencer.
// Holds the state encoding and default PATTERN, SHIFT_LEN, TIMEOUT.
package waveform_pkg;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    SHIFT    = 2'd1,
    COUNT    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam logic [3:0]  DEF_PATTERN   = 4'b1101;
  localparam int          DEF_SHIFT_LEN = 4;
  localparam logic [15:0] DEF_TIMEOUT   = 16'd1000;

endpackage

// File: rtl/shift_count_sequencer_if.sv
// Control bundle between the sequencer and its datapath/host.
// master: data, done_counting, ack out; slave: enables and status out.
interface shift_count_sequencer_if;

  logic data;
  logic done_counting;
  logic ack;
  logic shift_ena;
  logic count_ena;
  logic counting;
  logic done;
  logic err;

  modport master (
    output data,
    output done_counting,
    output ack,
    input  shift_ena,
    input  count_ena,
    input  counting,
    input  done,
    input  err
  );

  modport slave (
    input  data,
    input  done_counting,
    input  ack,
    output shift_ena,
    output count_ena,
    output counting,
    output done,
    output err
  );

endinterface

// File: rtl/pattern_detect.sv
// Overlapping serial start-code detector, MSB first.
// Ports: clk, resetn, clr (drop history), en (shift in data), data -> match.
module pattern_detect
  import waveform_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  input  logic data,
  output logic match
);

  logic [2:0] hist;
  logic [1:0] fill;

  // fill keeps a cleared (all-zero) history from
  // matching a pattern that starts with zeros
  assign match = en && (fill == 2'd3) &&
                 ({hist, data} == PATTERN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= {hist[1:0], data};
      if (fill != 2'd3)
        fill <= fill + 2'd1;
    end
  end

endmodule

// File: rtl/shift_count_sequencer.sv
// Start-code triggered shift/count sequencer with timeout, Moore outputs.
// Ports: clk, resetn, bus (data, done_counting, ack in; enables/status out).
module shift_count_sequencer
  import waveform_pkg::*;
#(
  parameter logic [3:0]  PATTERN   = DEF_PATTERN,
  parameter int          SHIFT_LEN = DEF_SHIFT_LEN,
  parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
  input logic clk,
  input logic resetn,
  shift_count_sequencer_if.slave bus
);

  localparam int SW = $clog2(SHIFT_LEN) + 1;

  state_t        state, state_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [15:0]   tcnt, tcnt_n;
  logic          err_q, err_n;
  logic          match;
  logic          det_en;
  logic          det_clr;
  logic          tmo;

  // history is dropped for the whole of WAIT_ACK so
  // bits seen before the ack never join a new match
  assign det_en  = (state == SEARCH);
  assign det_clr = (state == WAIT_ACK);

  pattern_detect #(
    .PATTERN(PATTERN)
  ) u_det (
    .clk    (clk),
    .resetn (resetn),
    .clr    (det_clr),
    .en     (det_en),
    .data   (bus.data),
    .match  (match)
  );

  // true on the edge that completes the TIMEOUT-th
  // COUNT cycle
  assign tmo = ({1'b0, tcnt} + 17'd1) >= {1'b0, TIMEOUT};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SEARCH;
      scnt  <= '0;
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      tcnt  <= tcnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    tcnt_n  = tcnt;
    err_n   = err_q;
    unique case (state)
      SEARCH: begin
        if (match) begin
          state_n = SHIFT;
          scnt_n  = SW'(SHIFT_LEN - 1);
        end
      end
      SHIFT: begin
        if (scnt == '0) begin
          state_n = COUNT;
          tcnt_n  = '0;
        end else begin
          scnt_n = scnt - 1'b1;
        end
      end
      COUNT: begin
        if (tcnt != 16'hFFFF)
          tcnt_n = tcnt + 16'd1;
        if (bus.done_counting) begin
          state_n = WAIT_ACK;
          err_n   = 1'b0;
        end else if (tmo) begin
          state_n = WAIT_ACK;
          err_n   = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (bus.ack) begin
          state_n = SEARCH;
          err_n   = 1'b0;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  assign bus.shift_ena = (state == SHIFT);
  assign bus.count_ena = (state == COUNT);
  assign bus.counting  = (state == COUNT);
  assign bus.done      = (state == WAIT_ACK);
  assign bus.err       = (state == WAIT_ACK) && err_q;

endmodule
